// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command: operand loads, exec or product-unit handshake, flag write, result return.
// Latency accept->res_valid: nops+2 (plain), nops+3+N (product), 2 (flag load); holds result until res_ready.
module alu_op_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [1:0]  cmd_nops,
  input  logic        cmd_wf,
  input  logic        cmd_ldfl,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [15:0] cmd_d,
  output logic [15:0] alu_a,
  output logic [5:0]  alu_op,
  output logic        alu_wa,
  output logic        alu_wb,
  output logic        alu_wd,
  output logic [1:0]  alu_wr,
  output logic        alu_enadi,
  input  logic        alu_finp,
  input  logic [15:0] alu_r1,
  input  logic [15:0] alu_r2,
  input  logic [5:0]  alu_fl,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_r1,
  output logic [15:0] res_r2,
  output logic [5:0]  res_fl,
  output logic        res_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, LDA, LDB, LDD, EXEC, START, WAITP, FLAG, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [1:0]    nops_q, nops_d;
  logic          wf_q, wf_d;
  logic [15:0]   a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   r1_q, r1_d, r2_q, r2_d;
  logic [5:0]    fl_q, fl_d;
  logic          err_q, err_d;
  logic          fl_first_q, fl_first_d;
  state_t        exec_st;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      op_q       <= '0;
      nops_q     <= '0;
      wf_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      fl_q       <= '0;
      err_q      <= 1'b0;
      fl_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      nops_q     <= nops_d;
      wf_q       <= wf_d;
      a_q        <= a_d;
      b_q        <= b_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      fl_q       <= fl_d;
      err_q      <= err_d;
      fl_first_q <= fl_first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    nops_d    = nops_q;
    wf_d      = wf_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    alu_a     = '0;
    alu_wa    = 1'b0;
    alu_wb    = 1'b0;
    alu_wd    = 1'b0;
    alu_wr    = 2'b00;
    alu_enadi = 1'b0;
    res_valid = 1'b0;
    exec_st   = op_q[5] ? START : EXEC;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          nops_d  = (cmd_nops == 2'd0) ? 2'd1 : cmd_nops;
          wf_d    = cmd_wf;
          a_d     = cmd_a;
          b_d     = cmd_b;
          d_d     = cmd_d;
          err_d   = 1'b0;
          state_d = cmd_ldfl ? FLAG : LDA;
        end
      end
      LDA: begin
        alu_a   = a_q;
        alu_wa  = 1'b1;
        state_d = (nops_q >= 2'd2) ? LDB : exec_st;
      end
      LDB: begin
        alu_a   = b_q;
        alu_wb  = 1'b1;
        state_d = (nops_q == 2'd3) ? LDD : exec_st;
      end
      LDD: begin
        alu_a   = d_q;
        alu_wd  = 1'b1;
        state_d = exec_st;
      end
      EXEC: begin
        r1_d    = alu_r1;
        r2_d    = alu_r2;
        alu_wr  = wf_q ? 2'b01 : 2'b00;
        state_d = RESP;
      end
      START: begin
        alu_enadi = 1'b1;
        cnt_d     = '0;
        state_d   = WAITP;
      end
      WAITP: begin
        // FINP takes priority over expiry in the same cycle
        if (alu_finp) begin
          r1_d    = alu_r1;
          r2_d    = alu_r2;
          alu_wr  = wf_q ? 2'b01 : 2'b00;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          r1_d    = '0;
          r2_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLAG: begin
        alu_a   = a_q;
        alu_wr  = 2'b10;
        r1_d    = '0;
        r2_d    = '0;
        state_d = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags settle one cycle after the write, so they are taken live in the first RESP cycle and held after.
  assign fl_first_d = (state_d == RESP) && (state_q != RESP);
  assign fl_d       = fl_first_q ? alu_fl : fl_q;
  assign res_fl     = fl_first_q ? alu_fl : fl_q;
  assign res_r1     = r1_q;
  assign res_r2     = r2_q;
  assign res_err    = err_q;
  assign alu_op     = (state_q == IDLE) ? 6'd0 : op_q;

endmodule
